// File: rtl/hazard_controller.sv
// Pipeline hazard control for the 5-stage RV32 core: operand forwarding,
// stall/flush generation, mul/div sequencing and stall/redirect counters.
module hazard_controller #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             MDOpE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] RedirectCount
);

  localparam int               MD_CW    = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic             MD_MULTI = (MD_LATENCY > 1);
  localparam logic [MD_CW-1:0] MD_LOAD  = MD_CW'((MD_LATENCY > 1) ? MD_LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    MD_RUN,
    MD_BUSY
  } md_state_t;

  md_state_t        state_q, state_d;
  logic [MD_CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

  logic       lw_hazard;
  logic       mem_stall;
  logic       md_stall;
  logic       stall_fd;
  logic       flush_d_raw;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // Memory-stage result is younger than Writeback, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a     = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    fwd_b     = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    lw_hazard = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
    mem_stall = MemReqM && !MemReadyM;
    md_stall  = ((state_q == MD_RUN) && MDOpE && MD_MULTI) ||
                ((state_q == MD_BUSY) && (cnt_q != '0));
  end

  // Sequencer freezes while memory stalls, since Execute cannot advance then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_stall) begin
      case (state_q)
        MD_RUN: begin
          if (MDOpE && MD_MULTI) begin
            state_d = MD_BUSY;
            cnt_d   = MD_LOAD;
          end
        end
        MD_BUSY: begin
          if (cnt_q == '0) begin
            state_d = MD_RUN;
          end else begin
            cnt_d = cnt_q - MD_CW'(1);
          end
        end
        default: begin
          state_d = MD_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A taken redirect beats load-use so the new PC is fetched rather than held.
  always_comb begin
    stall_fd    = mem_stall | md_stall | (lw_hazard & !PCSrcE);
    flush_d_raw = PCSrcE & !mem_stall & !md_stall;

    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushM    = 1'b1;
    FlushW    = 1'b1;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      StallF    = stall_fd;
      StallD    = stall_fd;
      StallE    = mem_stall | md_stall;
      StallM    = mem_stall;
      FlushD    = flush_d_raw;
      FlushE    = (PCSrcE | lw_hazard) & !mem_stall & !md_stall;
      FlushM    = md_stall & !mem_stall;
      FlushW    = mem_stall;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
    end
  end

  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if (stall_fd && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (flush_d_raw && (redirect_count_q != CNT_MAX)) begin
      redirect_count_d = redirect_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= MD_RUN;
      cnt_q            <= '0;
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign StallCycles   = stall_cycles_q;
  assign RedirectCount = redirect_count_q;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline control for the 5-stage RV32 core.
- Generates stall, flush and forwarding controls for the F/D, D/E, E/M and M/W pipeline registers. Sources of hazard: load-use dependences, taken branches and jumps, a multi-cycle mul/div unit in Execute, and a data memory that can stall.
- Keeps the multi-cycle sequencing state and two performance counters.

Parameters:
- MD_LATENCY, 4: cycles a mul/div op occupies Execute. Legal range is ≥1; 1 means it never stalls.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute
- ResultSrcE  in  2  value 2'b01 marks a load in Execute
- MDOpE  in  1  mul/div op in Execute
- PCSrcE  in  1  taken branch or jump resolved in Execute
- RdM  in  5  destination register in Memory
- RegWriteM  in  1  Memory-stage write enable
- MemReqM  in  1  data memory access in Memory
- MemReadyM  in  1  data memory completes this cycle
- RdW  in  5  destination register in Writeback
- RegWriteW  in  1  Writeback-stage write enable
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushM, FlushW  out  1  bubble the corresponding pipeline register
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 Writeback result, 10 Memory ALU result
- StallCycles  out  CNT_W  count of cycles with StallF=1
- RedirectCount  out  CNT_W  count of cycles with FlushD=1

Behaviour:
Forwarding (combinational):
- ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
- Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
- Otherwise ForwardAE=00.
- ForwardBE uses the same rules with Rs2E.
- Memory stage has priority over Writeback.

Hazard terms:
- lw = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- mem = MemReqM && !MemReadyM.

mul/div sequencer:
- States RUN and BUSY, plus counter cnt.
- md = (RUN && MDOpE && MD_LATENCY>1) || (BUSY && cnt!=0).
- RUN with MDOpE && MD_LATENCY>1 && !mem: go to BUSY, cnt<=MD_LATENCY-2.
- BUSY with !mem: if cnt==0 go to RUN, else cnt<=cnt-1.
- While mem=1, state and cnt hold.
- Result: the op occupies Execute for exactly MD_LATENCY cycles plus any mem cycles, giving MD_LATENCY-1 md stall cycles.

Outputs:
- StallF = StallD = mem | md | (lw & !PCSrcE). A taken redirect overrides load-use so the redirected PC loads.
- StallE = mem | md.
- StallM = mem.
- FlushD = PCSrcE & !mem & !md.
- FlushE = (PCSrcE | lw) & !mem & !md.
- FlushM = md & !mem.
- FlushW = mem.
- When mem=1, a redirect is deferred: Execute is frozen, so PCSrcE stays asserted until Execute advances.

Counters:
- Both counters increment at the clock edge when their condition holds.
- Both saturate at all-ones; they do not wrap.

Reset (rst_n=0 at an edge):
- state=RUN, cnt=0, both counters=0.
- While rst_n=0, outputs are forced: all Stall*=0, all Flush*=1, Forward*=00.
- Reset in mid-BUSY abandons the op; after release, sequencing restarts in RUN.

Test Plan:
- RdM=5, RegWriteM=1, Rs1E=5; also RdW=5, RegWriteW=1 -> ForwardAE=10. Clear RegWriteM -> 01. Set RdM=RdW=0 -> 00.
- Load in E (ResultSrcE=01, RdE=7), Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for one cycle, StallCycles +1. Same with PCSrcE=1 -> FlushD=FlushE=1, StallF=0, RedirectCount +1.
- MD_LATENCY=4, MDOpE held 4 cycles -> StallF/D/E=1 and FlushM=1 in cycles 1-3, all 0 in cycle 4; next MDOpE restarts sequencing. MD_LATENCY=1 -> no stalls.
- mul/div in cycle 2 of BUSY with MemReqM=1, MemReadyM=0 for 3 cycles -> StallF/D/E/M=1, FlushW=1, FlushM=0, cnt frozen; total E occupancy 4+3=7 cycles.
- PCSrcE=1 during mem stall -> FlushD=FlushE=0 until MemReadyM=1, then both 1 for that cycle.
- Preload StallCycles to all-ones via a long stall -> holds all-ones. rst_n=0 mid-BUSY -> next cycle state RUN, counters 0, Flush*=1 while low.
